// File: rtl/fwd_hazard_unit_pkg.sv
// Shared constants and helpers for the forwarding / load-use hazard unit.
// The select encoding reserves 0 for the register file; k selects the stage-k result.
package fwd_hazard_unit_pkg;

   localparam int REG_AW_DEF = 5;
   localparam int FWD_RF     = 0;

   // A ready stage of 0 means "ALU-like"; anything past the tracked depth is forwardable last.
   function automatic int clamp_ready(input int ready_stage, input int depth);
      if (ready_stage < 1)
         return 1;
      if (ready_stage > depth)
         return depth;
      return ready_stage;
   endfunction

endpackage

// File: rtl/fwd_hazard_unit_if.sv
// ID-stage request / EX-stage forward-select bundle of the hazard unit.
interface fwd_hazard_unit_if #(
   parameter int REG_AW  = 5,
   parameter int NUM_SRC = 2,
   parameter int LAT_W   = 2,
   parameter int SEL_W   = 2,
   parameter int CNT_W   = 16
);
   logic                      hold;
   logic                      flush;
   logic                      id_valid;
   logic [NUM_SRC*REG_AW-1:0] id_rs;
   logic [NUM_SRC-1:0]        id_rs_used;
   logic [REG_AW-1:0]         id_rd;
   logic                      id_reg_write;
   logic [LAT_W-1:0]          id_ready_stage;
   logic [NUM_SRC*SEL_W-1:0]  forward_sel;
   logic                      stall_id;
   logic [CNT_W-1:0]          stall_count;

   modport master (
      output hold, flush, id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_ready_stage,
      input  forward_sel, stall_id, stall_count
   );

   modport slave (
      input  hold, flush, id_valid, id_rs, id_rs_used, id_rd, id_reg_write, id_ready_stage,
      output forward_sel, stall_id, stall_count
   );
endinterface

// File: rtl/fwd_hazard_unit_src_match.sv
// Priority matcher for one source operand against the in-flight scoreboard.
// Youngest producer wins; reports a stall when that producer's result is not yet forwardable.
module fwd_src_match
   import fwd_hazard_unit_pkg::*;
#(
   parameter int REG_AW = 5,
   parameter int DEPTH  = 2,
   parameter int LAT_W  = 2,
   parameter int SEL_W  = 2
) (
   input  logic                    id_valid,
   input  logic                    rs_used,
   input  logic [REG_AW-1:0]       rs,
   input  logic [DEPTH-1:0]        sb_valid,
   input  logic [DEPTH*REG_AW-1:0] sb_rd,
   input  logic [DEPTH*LAT_W-1:0]  sb_ready,
   output logic [SEL_W-1:0]        sel,
   output logic                    not_ready
);

   always_comb begin
      sel       = SEL_W'(FWD_RF);
      not_ready = 1'b0;
      // Walk oldest to youngest so the youngest match overrides.
      for (int j = DEPTH - 1; j >= 0; j--) begin
         if (id_valid && rs_used && sb_valid[j] && (sb_rd[j*REG_AW +: REG_AW] == rs)) begin
            if ((j + 1) < int'(sb_ready[j*LAT_W +: LAT_W])) begin
               not_ready = 1'b1;
               sel       = SEL_W'(FWD_RF);
            end else begin
               not_ready = 1'b0;
               sel       = SEL_W'(j + 1);
            end
         end
      end
   end

endmodule

// File: rtl/fwd_hazard_unit.sv
// Forwarding + load-use hazard unit: in-flight destination scoreboard, registered
// per-source forward selects aligned to EX, ID stall generation and a saturating stall counter.
module fwd_hazard_unit
   import fwd_hazard_unit_pkg::*;
#(
   parameter int REG_AW  = REG_AW_DEF,
   parameter int NUM_SRC = 2,
   parameter int DEPTH   = 2,
   parameter int LAT_W   = 2,
   parameter int SEL_W   = $clog2(DEPTH + 1),
   parameter int CNT_W   = 16
) (
   input logic               clk,
   input logic               rst,
   fwd_hazard_unit_if.slave  bus
);

   typedef struct packed {
      logic              valid;
      logic [REG_AW-1:0] rd;
      logic [LAT_W-1:0]  ready_stage;
   } sb_entry_t;

   // Entry k holds the producer currently in EX (k=0) or stage k. The entry that would sit
   // in the last stage is never matched, so it is not stored.
   sb_entry_t                 sb_reg [DEPTH];
   sb_entry_t                 id_entry;
   logic [NUM_SRC*SEL_W-1:0]  forward_sel_reg;
   logic [NUM_SRC*SEL_W-1:0]  forward_sel_next;
   logic [CNT_W-1:0]          stall_count_reg;
   logic [NUM_SRC-1:0]        not_ready;
   logic [DEPTH-1:0]          sb_valid;
   logic [DEPTH*REG_AW-1:0]   sb_rd;
   logic [DEPTH*LAT_W-1:0]    sb_ready;
   logic                      stall;

   genvar gi;
   generate
      for (gi = 0; gi < DEPTH; gi++) begin : g_flat
         assign sb_valid[gi]                   = sb_reg[gi].valid;
         assign sb_rd[gi*REG_AW +: REG_AW]     = sb_reg[gi].rd;
         assign sb_ready[gi*LAT_W +: LAT_W]    = sb_reg[gi].ready_stage;
      end

      for (gi = 0; gi < NUM_SRC; gi++) begin : g_src
         fwd_src_match #(
            .REG_AW (REG_AW),
            .DEPTH  (DEPTH),
            .LAT_W  (LAT_W),
            .SEL_W  (SEL_W)
         ) u_match (
            .id_valid  (bus.id_valid),
            .rs_used   (bus.id_rs_used[gi]),
            .rs        (bus.id_rs[gi*REG_AW +: REG_AW]),
            .sb_valid  (sb_valid),
            .sb_rd     (sb_rd),
            .sb_ready  (sb_ready),
            .sel       (forward_sel_next[gi*SEL_W +: SEL_W]),
            .not_ready (not_ready[gi])
         );
      end
   endgenerate

   always_comb begin
      id_entry             = '0;
      id_entry.valid       = bus.id_valid & bus.id_reg_write & (bus.id_rd != '0);
      id_entry.rd          = bus.id_rd;
      id_entry.ready_stage = LAT_W'(clamp_ready(int'(bus.id_ready_stage), DEPTH));
   end

   assign stall = (|not_ready) & ~bus.flush & ~bus.hold;

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int k = 0; k < DEPTH; k++)
            sb_reg[k] <= '0;
         forward_sel_reg <= '0;
         stall_count_reg <= '0;
      end else if (!bus.hold) begin
         // A flush kills the instruction leaving EX, so it never reaches stage 1.
         for (int k = 1; k < DEPTH; k++)
            sb_reg[k] <= (k == 1 && bus.flush) ? '0 : sb_reg[k-1];
         if (bus.flush) begin
            sb_reg[0]       <= '0;
            forward_sel_reg <= '0;
         end else if (stall) begin
            sb_reg[0]       <= '0;
            forward_sel_reg <= '0;
            if (stall_count_reg != '1)
               stall_count_reg <= stall_count_reg + CNT_W'(1);
         end else begin
            sb_reg[0]       <= id_entry;
            forward_sel_reg <= forward_sel_next;
         end
      end
   end

   assign bus.forward_sel = forward_sel_reg;
   assign bus.stall_id    = stall;
   assign bus.stall_count = stall_count_reg;

endmodule

// File: tb/tb_fwd_hazard_unit.sv
// Directed bench for fwd_hazard_unit: default instance plus a CNT_W=2 instance sharing stimulus.
module tb_fwd_hazard_unit;

   logic clk = 1'b0;
   logic rst = 1'b1;
   int   n_tests = 0;
   int   n_fail  = 0;

   always #5 clk = ~clk;

   fwd_hazard_unit_if #(.CNT_W(16)) bus ();
   fwd_hazard_unit_if #(.CNT_W(2))  bus_sat ();

   fwd_hazard_unit #(.CNT_W(16)) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   fwd_hazard_unit #(.CNT_W(2)) dut_sat (
      .clk (clk),
      .rst (rst),
      .bus (bus_sat)
   );

   assign bus_sat.hold           = bus.hold;
   assign bus_sat.flush          = bus.flush;
   assign bus_sat.id_valid       = bus.id_valid;
   assign bus_sat.id_rs          = bus.id_rs;
   assign bus_sat.id_rs_used     = bus.id_rs_used;
   assign bus_sat.id_rd          = bus.id_rd;
   assign bus_sat.id_reg_write   = bus.id_reg_write;
   assign bus_sat.id_ready_stage = bus.id_ready_stage;

   task automatic chk(input string tag, input int got, input int exp);
      n_tests++;
      if (got != exp) begin
         n_fail++;
         $display("[TB] FAIL %s: got %0d, expected %0d", tag, got, exp);
      end else begin
         $display("[TB] ok   %s: %0d", tag, got);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic issue(input logic v, input logic [4:0] rs1, input logic [4:0] rs2,
                        input logic [1:0] used, input logic [4:0] rd, input logic rw,
                        input logic [1:0] rdy);
      bus.id_valid       = v;
      bus.id_rs          = {rs2, rs1};
      bus.id_rs_used     = used;
      bus.id_rd          = rd;
      bus.id_reg_write   = rw;
      bus.id_ready_stage = rdy;
      #1;
   endtask

   function automatic int sel0();
      return int'(bus.forward_sel[1:0]);
   endfunction

   function automatic int sel1();
      return int'(bus.forward_sel[3:2]);
   endfunction

   initial begin
      bus.hold  = 1'b0;
      bus.flush = 1'b0;
      issue(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd1);

      // Reset state
      step();
      chk("rst_sel", int'(bus.forward_sel), 0);
      chk("rst_stall", int'(bus.stall_id), 0);
      chk("rst_cnt", int'(bus.stall_count), 0);
      rst = 1'b0;

      // ALU producer rd=5, next instr reads rs1=5
      issue(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 2'd1);
      step();
      issue(1'b1, 5'd5, 5'd0, 2'b01, 5'd0, 1'b0, 2'd1);
      chk("alu_stall", int'(bus.stall_id), 0);
      step();
      chk("alu_sel0", sel0(), 1);
      chk("alu_sel1", sel1(), 0);

      // Producer, independent instr, consumer rs2=5 -> stage 2
      issue(1'b1, 5'd0, 5'd0, 2'b00, 5'd5, 1'b1, 2'd1);
      step();
      issue(1'b1, 5'd1, 5'd2, 2'b11, 5'd9, 1'b1, 2'd1);
      step();
      issue(1'b1, 5'd0, 5'd5, 2'b10, 5'd0, 1'b0, 2'd1);
      chk("gap_stall", int'(bus.stall_id), 0);
      step();
      chk("gap_sel1", sel1(), 2);
      chk("gap_sel0", sel0(), 0);

      // Load-use: one stall cycle, then forward from stage 2
      issue(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 2'd2);
      step();
      issue(1'b1, 5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 2'd1);
      chk("lu_stall", int'(bus.stall_id), 1);
      step();
      chk("lu_cnt", int'(bus.stall_count), 1);
      chk("lu_bubble_sel0", sel0(), 0);
      chk("lu_stall_clear", int'(bus.stall_id), 0);
      step();
      chk("lu_sel0", sel0(), 2);
      chk("lu_cnt_hold", int'(bus.stall_count), 1);

      // Stages 1 and 2 both write rd=7: youngest wins for both sources
      issue(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd1);
      step();
      issue(1'b1, 5'd0, 5'd0, 2'b00, 5'd7, 1'b1, 2'd1);
      step();
      issue(1'b1, 5'd7, 5'd7, 2'b11, 5'd0, 1'b0, 2'd1);
      chk("young_stall", int'(bus.stall_id), 0);
      step();
      chk("young_sel0", sel0(), 1);
      chk("young_sel1", sel1(), 1);

      // rd=0 producer never forwards
      issue(1'b1, 5'd0, 5'd0, 2'b00, 5'd0, 1'b1, 2'd1);
      step();
      issue(1'b1, 5'd0, 5'd0, 2'b01, 5'd0, 1'b0, 2'd1);
      step();
      chk("r0_sel0", sel0(), 0);

      // Flush with load in EX suppresses the stall and kills the load
      issue(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 2'd2);
      step();
      bus.flush = 1'b1;
      issue(1'b1, 5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 2'd1);
      chk("flush_stall", int'(bus.stall_id), 0);
      step();
      bus.flush = 1'b0;
      chk("flush_sel0", sel0(), 0);
      issue(1'b1, 5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 2'd1);
      chk("flush_killed_stall", int'(bus.stall_id), 0);
      step();
      chk("flush_killed_sel0", sel0(), 0);

      // Hold during load-use: everything frozen
      issue(1'b1, 5'd0, 5'd0, 2'b00, 5'd3, 1'b1, 2'd1);
      step();
      issue(1'b1, 5'd3, 5'd0, 2'b01, 5'd6, 1'b1, 2'd2);
      step();
      chk("hold_pre_sel0", sel0(), 1);
      issue(1'b1, 5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 2'd1);
      chk("hold_pre_stall", int'(bus.stall_id), 1);
      bus.hold = 1'b1;
      #1;
      chk("hold_stall", int'(bus.stall_id), 0);
      step();
      step();
      chk("hold_sel0", sel0(), 1);
      chk("hold_cnt", int'(bus.stall_count), 1);
      bus.hold = 1'b0;
      #1;
      chk("unhold_stall", int'(bus.stall_id), 1);
      step();
      chk("unhold_cnt", int'(bus.stall_count), 2);
      chk("unhold_sel0", sel0(), 0);

      // Async reset in the middle of a stall
      issue(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 2'd2);
      step();
      issue(1'b1, 5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 2'd1);
      chk("rst2_pre_stall", int'(bus.stall_id), 1);
      rst = 1'b1;
      #1;
      chk("rst2_cnt", int'(bus.stall_count), 0);
      chk("rst2_stall", int'(bus.stall_id), 0);
      chk("rst2_sel", int'(bus.forward_sel), 0);
      issue(1'b0, 5'd0, 5'd0, 2'b00, 5'd0, 1'b0, 2'd1);
      step();
      rst = 1'b0;
      step();

      // Five load-use stalls: narrow counter saturates at 3
      for (int i = 0; i < 5; i++) begin
         issue(1'b1, 5'd0, 5'd0, 2'b00, 5'd6, 1'b1, 2'd2);
         step();
         issue(1'b1, 5'd6, 5'd0, 2'b01, 5'd0, 1'b0, 2'd1);
         step();
         step();
      end
      chk("sat_cnt", int'(bus_sat.stall_count), 3);
      chk("wide_cnt", int'(bus.stall_count), 5);

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

endmodule
